// File: rtl/env_note_player.sv
// env_note_player: single-voice note player with a phase accumulator and a
// linear attack/release envelope. It loads a note and a duration from the
// song reader, counts 48 Hz beats, drives the frequency ROM and the sine ROM,
// and hands enveloped samples to the codec on a request/ready handshake.
module env_note_player #(
   parameter int NOTE_W       = 6,
   parameter int DUR_W        = 6,
   parameter int STEP_W       = 20,
   parameter int ADDR_W       = 10,
   parameter int SAMPLE_W     = 16,
   parameter int ENV_W        = 8,
   parameter int ATTACK_STEP  = 8,
   parameter int RELEASE_STEP = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       play_enable,
   input  logic                       load_new_note,
   input  logic [NOTE_W-1:0]          note_to_load,
   input  logic [DUR_W-1:0]           duration_to_load,
   input  logic                       beat,
   input  logic                       generate_next_sample,
   output logic                       done_with_note,
   output logic [NOTE_W-1:0]          note_addr,
   input  logic [STEP_W-1:0]          step_size,
   output logic [ADDR_W-1:0]          sine_addr,
   input  logic signed [SAMPLE_W-1:0] sine_data,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       new_sample_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD1,
      S_LOAD2,
      S_PLAY,
      S_RELEASE,
      S_DONE
   } state_t;

   localparam logic [ENV_W-1:0] GAIN_FULL = '1;
   localparam logic [ENV_W:0]   ATK_INC   = (ENV_W+1)'(ATTACK_STEP);
   localparam logic [ENV_W-1:0] REL_DEC   = ENV_W'(RELEASE_STEP);
   localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
   localparam int               PROD_W    = SAMPLE_W + ENV_W + 1;

   // control state
   state_t               state_q;
   logic [NOTE_W-1:0]    note_q;
   logic [DUR_W-1:0]     dur_q;
   logic [DUR_W-1:0]     beat_cnt_q;
   logic [STEP_W-1:0]    step_q;
   logic                 done_q;

   // oscillator / envelope state
   logic [STEP_W-1:0]    phase_q, phase_d;
   logic [ENV_W-1:0]     gain_q, gain_d;
   logic [ENV_W:0]       gain_sum;

   // sample pipeline: request cycle -> ROM read cycle -> output
   logic [ADDR_W-1:0]    sine_addr_q;
   logic                 req1_q;
   logic [ENV_W-1:0]     gain1_q;
   logic signed [SAMPLE_W-1:0] sample_q;
   logic                 ready_q;
   logic signed [PROD_W-1:0]   prod;

   logic playing;
   logic load_ok;

   assign playing  = (state_q == S_PLAY) || (state_q == S_RELEASE);
   // A load is accepted everywhere except in the two ROM access states.
   assign load_ok  = play_enable && load_new_note &&
                     (state_q != S_LOAD1) && (state_q != S_LOAD2);
   assign gain_sum = {1'b0, gain_q} + ATK_INC;

   // Next phase and gain: cleared on disable/load, otherwise stepped by a request
   always_comb begin
      phase_d = phase_q;
      gain_d  = gain_q;
      if (!play_enable || load_ok) begin
         phase_d = '0;
         gain_d  = '0;
      end else if (generate_next_sample && playing) begin
         phase_d = phase_q + step_q;
         if (state_q == S_PLAY) begin
            gain_d = gain_sum[ENV_W] ? GAIN_FULL : gain_sum[ENV_W-1:0];
         end else begin
            gain_d = (gain_q > REL_DEC) ? (gain_q - REL_DEC) : '0;
         end
      end
   end

   // Signed sine times unsigned gain; gain is zero-extended so it stays positive
   assign prod = $signed({{(ENV_W+1){sine_data[SAMPLE_W-1]}}, sine_data}) *
                 $signed({{(SAMPLE_W+1){1'b0}}, gain1_q});

   // Note FSM: load handshake, beat counting, release and done flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         note_q     <= '0;
         dur_q      <= '0;
         beat_cnt_q <= '0;
         step_q     <= '0;
         done_q     <= 1'b0;
      end else if (!play_enable) begin
         state_q    <= S_IDLE;
         note_q     <= '0;
         dur_q      <= '0;
         beat_cnt_q <= '0;
         step_q     <= '0;
         done_q     <= 1'b0;
      end else if (load_ok) begin
         // load wins over a coinciding beat expiry or release completion
         state_q    <= S_LOAD1;
         note_q     <= note_to_load;
         dur_q      <= duration_to_load;
         beat_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD1: state_q <= S_LOAD2;
            S_LOAD2: begin
               // frequency ROM has had a full cycle on note_addr
               step_q <= step_size;
               if (dur_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (beat) begin
                  beat_cnt_q <= beat_cnt_q + DUR_ONE;
                  if (beat_cnt_q == dur_q - DUR_ONE) state_q <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (gain_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Phase/gain registers and the two-stage sample pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q     <= '0;
         gain_q      <= '0;
         sine_addr_q <= '0;
         req1_q      <= 1'b0;
         gain1_q     <= '0;
         sample_q    <= '0;
         ready_q     <= 1'b0;
      end else begin
         phase_q <= phase_d;
         gain_q  <= gain_d;
         // address from the freshly advanced phase; ROM data is sampled next cycle
         if (generate_next_sample) sine_addr_q <= phase_d[STEP_W-1 -: ADDR_W];
         req1_q  <= generate_next_sample;
         gain1_q <= gain_d;
         ready_q <= req1_q;
         // in-flight samples still complete after a disable, but as silence
         if (req1_q) sample_q <= play_enable ? SAMPLE_W'(prod >>> ENV_W) : '0;
      end
   end

   assign done_with_note   = done_q;
   assign note_addr        = note_q;
   assign sine_addr        = sine_addr_q;
   assign sample_out       = sample_q;
   assign new_sample_ready = ready_q;

endmodule

// File: tb/tb_env_note_player.sv
// Self-checking bench for env_note_player: async ROM models, a cycle-level
// behavioural model of the note player, and a sample scoreboard.
module tb_env_note_player;

   localparam int NOTE_W = 6, DUR_W = 6, STEP_W = 20, ADDR_W = 10;
   localparam int SAMPLE_W = 16, ENV_W = 8;
   localparam int M_IDLE = 0, M_LOAD1 = 1, M_LOAD2 = 2, M_PLAY = 3, M_REL = 4, M_DONE = 5;

   logic clk = 1'b0;
   logic reset;
   logic pe, ld, bt, rq;
   logic [NOTE_W-1:0] nt;
   logic [DUR_W-1:0]  du;
   logic done_with_note, new_sample_ready;
   logic [NOTE_W-1:0] note_addr;
   logic [STEP_W-1:0] step_size;
   logic [ADDR_W-1:0] sine_addr;
   logic signed [SAMPLE_W-1:0] sine_data, sample_out;
   logic sine_const;

   int total = 0;
   int bad = 0;

   // behavioural model state
   int          m_state, m_gain, m_beats, m_dur, m_note;
   longint      m_phase, m_step;
   logic [ADDR_W-1:0] m_saddr;
   bit          pend_v;
   logic [15:0] pend_val;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [STEP_W-1:0] step_rom(input logic [NOTE_W-1:0] n);
      logic [STEP_W-1:0] t;
      if (n == 6'd5) return 20'h04A00;
      t = {14'h0, n};
      return t * 20'h00321 + 20'h00777;
   endfunction

   function automatic logic [15:0] sine_rom(input logic [ADDR_W-1:0] a, input logic cst);
      logic [15:0] t;
      if (cst) return 16'h4000;
      t = {6'h0, a};
      return t * 16'd40503 + 16'd12345;
   endfunction

   assign step_size = step_rom(note_addr);
   assign sine_data = sine_rom(sine_addr, sine_const);

   env_note_player dut (
      .clk(clk), .reset(reset), .play_enable(pe), .load_new_note(ld),
      .note_to_load(nt), .duration_to_load(du), .beat(bt),
      .generate_next_sample(rq), .done_with_note(done_with_note),
      .note_addr(note_addr), .step_size(step_size), .sine_addr(sine_addr),
      .sine_data(sine_data), .sample_out(sample_out),
      .new_sample_ready(new_sample_ready)
   );

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_gain = 0; m_beats = 0; m_dur = 0; m_note = 0;
      m_phase = 0; m_step = 0; m_saddr = '0; pend_v = 0; pend_val = '0;
      exp_q.delete();
   endtask

   // Apply one cycle of the note player rules to the current inputs.
   task automatic model_eval();
      int g_n;
      longint ph_n, p;
      logic signed [15:0] sv;
      bit ld_ok;
      ld_ok = pe && ld && (m_state != M_LOAD1) && (m_state != M_LOAD2);
      // previous request's sample: silenced if play is disabled this cycle
      if (pend_v) begin
         exp_q.push_back(pe ? pend_val : 16'h0);
         pend_v = 0;
      end
      g_n = m_gain;
      ph_n = m_phase;
      if (!pe || ld_ok) begin
         g_n = 0; ph_n = 0;
      end else if (rq && (m_state == M_PLAY || m_state == M_REL)) begin
         ph_n = (m_phase + m_step) % (64'd1 << STEP_W);
         if (m_state == M_PLAY) g_n = (m_gain + 8 > 255) ? 255 : m_gain + 8;
         else                   g_n = (m_gain < 4) ? 0 : m_gain - 4;
      end
      if (rq) begin
         m_saddr = ADDR_W'(ph_n >> (STEP_W - ADDR_W));
         sv = sine_rom(m_saddr, sine_const);
         p = longint'(sv) * longint'(g_n);
         p = p >>> ENV_W;
         pend_val = p[15:0];
         pend_v = 1;
      end
      if (!pe) begin
         m_state = M_IDLE; m_note = 0; m_step = 0; m_beats = 0; m_dur = 0;
      end else if (ld_ok) begin
         m_state = M_LOAD1; m_note = nt; m_dur = du; m_beats = 0;
      end else begin
         case (m_state)
            M_LOAD1: m_state = M_LOAD2;
            M_LOAD2: begin
               m_step = step_rom(NOTE_W'(m_note));
               m_state = (m_dur == 0) ? M_DONE : M_PLAY;
            end
            M_PLAY: if (bt) begin
               m_beats++;
               if (m_beats == m_dur) m_state = M_REL;
            end
            M_REL: if (m_gain == 0) m_state = M_DONE;
            default: ;
         endcase
      end
      m_gain = g_n;
      m_phase = ph_n;
   endtask

   // One clock: model, edge, then check the observable control outputs.
   task automatic cyc();
      model_eval();
      @(posedge clk);
      #1;
      check("done_with_note", done_with_note, (m_state == M_DONE));
      check("note_addr", note_addr, m_note);
      check("sine_addr", sine_addr, m_saddr);
      ld = 0; bt = 0; rq = 0;
   endtask

   task automatic load(input int n, input int d);
      nt = NOTE_W'(n); du = DUR_W'(d); ld = 1;
      cyc();
   endtask

   task automatic run_until_done(input string nm, input int budget);
      int n = 0;
      while (m_state != M_DONE && n < budget) begin
         rq = ($urandom_range(0, 1) == 1);
         bt = ($urandom_range(0, 9) == 0);
         cyc();
         n++;
      end
      if (m_state != M_DONE) begin
         bad++; total++;
         $display("FAIL %s: note did not finish within %0d cycles", nm, budget);
      end else begin
         check(nm, done_with_note, 1);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [15:0] e;
      if (!reset && new_sample_ready) begin
         if (exp_q.size() == 0) begin
            bad++; total++;
            $display("FAIL sample_unexpected: got ready with %0h, want no sample", sample_out);
         end else begin
            e = exp_q.pop_front();
            check("sample_out", $unsigned(sample_out), e);
         end
      end
   end

   initial begin
      reset = 1; pe = 0; ld = 0; bt = 0; rq = 0; nt = '0; du = '0;
      sine_const = 0;
      model_reset();
      @(posedge clk); #1;
      check("rst_done", done_with_note, 0);
      check("rst_note_addr", note_addr, 0);
      check("rst_sine_addr", sine_addr, 0);
      check("rst_sample_out", $unsigned(sample_out), 0);
      check("rst_ready", new_sample_ready, 0);
      @(posedge clk); #1;
      reset = 0;

      // example note: 5, three beats, then release to DONE
      pe = 1;
      idle_cycles(2);
      load(5, 3);
      check("load_note_addr_T1", note_addr, 5);
      idle_cycles(2);
      run_until_done("note5_done", 3000);
      idle_cycles(3);

      // constant sine, requests every cycle: attack ramp then full-gain 0x3FC0
      sine_const = 1;
      load(9, 63);
      for (int i = 0; i < 60; i++) begin rq = 1; cyc(); end
      check("full_gain_sample", $unsigned(sample_out), 16'h3FC0);
      idle_cycles(4);
      sine_const = 0;

      // load in the same cycle as the expiring beat
      load(3, 2);
      idle_cycles(3);
      for (int i = 0; i < 6; i++) begin rq = 1; cyc(); end
      bt = 1; cyc();
      idle_cycles(2);
      bt = 1; nt = 6'd4; du = 6'd2; ld = 1; rq = 1;
      cyc();
      check("ld_vs_beat_done", done_with_note, 0);
      for (int i = 0; i < 4; i++) begin rq = 1; cyc(); end
      check("ld_vs_beat_done_later", done_with_note, 0);
      run_until_done("ld_vs_beat_finish", 3000);

      // silent note
      rq = 1; load(7, 0);
      rq = 1; cyc();
      rq = 1; cyc();
      check("dur0_done_T3", done_with_note, 1);
      for (int i = 0; i < 5; i++) begin rq = 1; cyc(); end

      // play_enable dropped mid-note with samples in flight
      load(5, 10);
      idle_cycles(2);
      for (int i = 0; i < 12; i++) begin rq = 1; cyc(); end
      pe = 0; rq = 1; cyc();
      check("pe_low_done", done_with_note, 0);
      check("pe_low_note_addr", note_addr, 0);
      for (int i = 0; i < 5; i++) begin rq = 1; cyc(); end
      pe = 1;
      idle_cycles(3);

      // random mix
      for (int i = 0; i < 500; i++) begin
         pe = ($urandom_range(0, 59) != 0);
         ld = ($urandom_range(0, 29) == 0);
         nt = NOTE_W'($urandom_range(0, 63));
         du = DUR_W'($urandom_range(0, 4));
         bt = ($urandom_range(0, 4) == 0);
         rq = ($urandom_range(0, 1) == 1);
         cyc();
      end
      pe = 1;
      idle_cycles(4);

      // async reset in the middle of a note
      sine_const = 1;
      load(5, 20);
      for (int i = 0; i < 40; i++) begin rq = 1; cyc(); end
      #2;
      reset = 1;
      #1;
      check("async_rst_done", done_with_note, 0);
      check("async_rst_note_addr", note_addr, 0);
      check("async_rst_sine_addr", sine_addr, 0);
      check("async_rst_sample_out", $unsigned(sample_out), 0);
      check("async_rst_ready", new_sample_ready, 0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 0;
      for (int i = 0; i < 5; i++) begin rq = 1; cyc(); end
      check("post_rst_idle_done", done_with_note, 0);
      idle_cycles(4);

      check("scoreboard_drained", exp_q.size(), 0);
      check("no_pending_sample", pend_v, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
